// File: rtl/dbg_cpu_ctl.sv
// Debug-side master: decodes debug register accesses for the breakpoint units,
// holds CPU control/status registers and runs the RUN/HALT/STEP controller.
module dbg_cpu_ctl #(
  parameter int          NB_BRK = 2,
  parameter logic [15:0] CPU_ID = 16'h4D31
) (
  input  logic                  mclk,
  input  logic                  por,
  input  logic [5:0]            dbg_addr,
  input  logic [15:0]           dbg_din,
  input  logic                  dbg_wr,
  input  logic                  dbg_rd,
  output logic [15:0]           dbg_dout,
  output logic [4*NB_BRK-1:0]   brk_reg_wr,
  output logic [4*NB_BRK-1:0]   brk_reg_rd,
  input  logic [16*NB_BRK-1:0]  brk_dout,
  input  logic [NB_BRK-1:0]     brk_halt,
  input  logic [NB_BRK-1:0]     brk_pnd,
  input  logic                  exec_done,
  input  logic                  cpu_halt_st,
  output logic                  dbg_halt_cmd,
  output logic                  dbg_cpu_reset
);

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STEP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_rst_brk_en;
  logic        r_cpu_rst;
  logic        r_step_done;
  logic        r_brk_evt;
  logic [15:0] r_dout;

  logic        w_ctl_wr;
  logic        w_stat_wr;
  logic        w_cmd_halt;
  logic        w_cmd_run;
  logic        w_cmd_istep;
  logic        w_brk_any;
  logic        w_rst_release;
  logic        w_step_done_set;
  logic        w_brk_hit;
  logic [15:0] w_brk_data;
  logic [3:0]  w_pnd;
  logic [15:0] w_ctl_val;
  logic [15:0] w_stat_val;
  logic [15:0] w_rd_data;
  logic        w_unused_din;

  genvar gi, gr;
  generate
    for (gi = 0; gi < NB_BRK; gi++) begin : g_unit
      for (gr = 0; gr < 4; gr++) begin : g_reg
        assign brk_reg_wr[4*gi+gr] = dbg_wr && (dbg_addr == 6'(8 + 4*gi + gr));
        assign brk_reg_rd[4*gi+gr] = dbg_rd && (dbg_addr == 6'(8 + 4*gi + gr));
      end
    end
  endgenerate

  assign w_ctl_wr    = dbg_wr && (dbg_addr == 6'd1);
  assign w_stat_wr   = dbg_wr && (dbg_addr == 6'd2);
  assign w_cmd_halt  = w_ctl_wr && dbg_din[0];
  assign w_cmd_run   = w_ctl_wr && dbg_din[1];
  assign w_cmd_istep = w_ctl_wr && dbg_din[2];
  assign w_brk_any   = |brk_halt;
  assign w_unused_din = &{1'b0, dbg_din[15:7], dbg_din[5:4]};

  // Releasing CPU reset halts the core if the enable is set before or by this write.
  assign w_rst_release = w_ctl_wr && r_cpu_rst && !dbg_din[6] &&
                         (r_rst_brk_en || dbg_din[3]);

  assign w_step_done_set = (r_state == ST_STEP) && exec_done;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_cmd_halt || w_brk_any || w_rst_release) w_state_next = ST_HALT;
      end
      ST_HALT: begin
        if (w_cmd_halt)       w_state_next = ST_HALT;
        else if (w_cmd_run)   w_state_next = ST_RUN;
        else if (w_cmd_istep) w_state_next = ST_STEP;
      end
      ST_STEP: begin
        if (w_cmd_halt)                   w_state_next = ST_HALT;
        else if (w_cmd_run)               w_state_next = ST_RUN;
        else if (w_brk_any || exec_done)  w_state_next = ST_HALT;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge mclk or posedge por) begin
    if (por) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge mclk or posedge por) begin
    if (por) begin
      r_rst_brk_en <= 1'b0;
      r_cpu_rst    <= 1'b0;
      r_step_done  <= 1'b0;
      r_brk_evt    <= 1'b0;
    end else begin
      if (w_ctl_wr) begin
        r_rst_brk_en <= dbg_din[3];
        r_cpu_rst    <= dbg_din[6];
      end
      // Set beats a coincident write-1-to-clear.
      r_step_done <= w_step_done_set || (r_step_done && !(w_stat_wr && dbg_din[1]));
      r_brk_evt   <= w_brk_any       || (r_brk_evt   && !(w_stat_wr && dbg_din[2]));
    end
  end

  always_comb begin
    w_brk_data = '0;
    for (int k = 0; k < NB_BRK; k++) w_brk_data = w_brk_data | brk_dout[16*k +: 16];
  end

  always_comb begin
    w_pnd = '0;
    w_pnd[NB_BRK-1:0] = brk_pnd;
  end

  assign w_brk_hit  = (dbg_addr >= 6'd8) && (dbg_addr < 6'(8 + 4*NB_BRK));
  assign w_ctl_val  = {9'd0, r_cpu_rst, 2'd0, r_rst_brk_en, 3'd0};
  assign w_stat_val = {8'd0, w_pnd, 1'b0, r_brk_evt, r_step_done, cpu_halt_st};

  always_comb begin
    w_rd_data = '0;
    case (dbg_addr)
      6'd0:    w_rd_data = CPU_ID;
      6'd1:    w_rd_data = w_ctl_val;
      6'd2:    w_rd_data = w_stat_val;
      default: w_rd_data = w_brk_hit ? w_brk_data : 16'd0;
    endcase
  end

  always_ff @(posedge mclk or posedge por) begin
    if (por)         r_dout <= '0;
    else if (dbg_rd) r_dout <= w_rd_data;
  end

  assign dbg_dout      = r_dout;
  assign dbg_halt_cmd  = (r_state == ST_HALT);
  assign dbg_cpu_reset = r_cpu_rst;

endmodule

// File: tb/tb_dbg_cpu_ctl.sv
// Directed bench for dbg_cpu_ctl: register reads go through a scoreboard queue,
// control outputs are compared directly against hand-computed values.
module tb_dbg_cpu_ctl;

  localparam int NB = 2;

  logic          mclk = 1'b0;
  logic          por;
  logic [5:0]    dbg_addr;
  logic [15:0]   dbg_din;
  logic          dbg_wr;
  logic          dbg_rd;
  logic [15:0]   dbg_dout;
  logic [4*NB-1:0]  brk_reg_wr;
  logic [4*NB-1:0]  brk_reg_rd;
  logic [16*NB-1:0] brk_dout;
  logic [NB-1:0] brk_halt;
  logic [NB-1:0] brk_pnd;
  logic          exec_done;
  logic          cpu_halt_st;
  logic          dbg_halt_cmd;
  logic          dbg_cpu_reset;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] exp;
    logic [5:0]  addr;
  } rd_exp_t;
  rd_exp_t sb_q[$];
  logic    rd_d1 = 1'b0;

  dbg_cpu_ctl #(.NB_BRK(NB), .CPU_ID(16'h4D31)) dut (
    .mclk(mclk), .por(por), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
    .dbg_wr(dbg_wr), .dbg_rd(dbg_rd), .dbg_dout(dbg_dout),
    .brk_reg_wr(brk_reg_wr), .brk_reg_rd(brk_reg_rd), .brk_dout(brk_dout),
    .brk_halt(brk_halt), .brk_pnd(brk_pnd), .exec_done(exec_done),
    .cpu_halt_st(cpu_halt_st), .dbg_halt_cmd(dbg_halt_cmd),
    .dbg_cpu_reset(dbg_cpu_reset)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk or posedge por) begin
    if (por) rd_d1 <= 1'b0;
    else     rd_d1 <= dbg_rd;
  end

  // Monitor: read data is presented the cycle after each dbg_rd strobe.
  always @(negedge mclk) begin
    if (rd_d1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected dbg_dout=%h with empty scoreboard", dbg_dout);
      end else begin
        rd_exp_t e;
        e = sb_q.pop_front();
        if (dbg_dout !== e.exp) begin
          errors++;
          $display("FAIL rd_%02h got %h expected %h", e.addr, dbg_dout, e.exp);
        end else
          $display("read  addr=%02h data=%h ok", e.addr, dbg_dout);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end else
      $display("check %s = %h ok", name, act);
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] e);
    rd_exp_t x;
    x.exp = e; x.addr = a;
    sb_q.push_back(x);
    dbg_addr = a; dbg_rd = 1'b1;
    tick();
    dbg_rd = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    dbg_addr = a; dbg_din = d; dbg_wr = 1'b1;
    tick();
    dbg_wr = 1'b0;
  endtask

  initial begin
    por = 1'b1; dbg_addr = '0; dbg_din = '0; dbg_wr = 1'b0; dbg_rd = 1'b0;
    brk_dout = '0; brk_halt = '0; brk_pnd = '0; exec_done = 1'b0; cpu_halt_st = 1'b0;
    repeat (3) tick();
    chk("rst_halt_cmd", 32'(dbg_halt_cmd), 32'd0);
    chk("rst_cpu_reset", 32'(dbg_cpu_reset), 32'd0);
    chk("rst_dout", 32'(dbg_dout), 32'd0);
    por = 1'b0;
    tick();

    // Identification and unmapped address
    rd(6'h00, 16'h4D31);
    rd(6'h05, 16'h0000);

    // Breakpoint unit register decode
    dbg_addr = 6'h0A; dbg_din = 16'h1234; dbg_wr = 1'b1;
    #1 chk("brk_reg_wr_0A", 32'(brk_reg_wr), 32'h04);
    tick();
    dbg_wr = 1'b0;
    #1 chk("brk_reg_wr_idle", 32'(brk_reg_wr), 32'h00);
    brk_dout = 32'h0000_1234;
    rd(6'h0A, 16'h1234);
    brk_dout = '0;
    tick(); tick();
    chk("dout_hold", 32'(dbg_dout), 32'h1234);
    dbg_addr = 6'h0C; dbg_rd = 1'b1;
    #1 chk("brk_reg_rd_0C", 32'(brk_reg_rd), 32'h10);
    sb_q.push_back('{exp: 16'h0000, addr: 6'h0C});
    tick();
    dbg_rd = 1'b0;

    // Breakpoint halt and sticky BRK_EVT
    brk_pnd = 2'b10;
    brk_halt = 2'b10;
    tick();
    brk_halt = '0;
    chk("brk_halt_cmd", 32'(dbg_halt_cmd), 32'd1);
    rd(6'h02, 16'h0024);
    wr(6'h02, 16'h0004);
    rd(6'h02, 16'h0020);
    dbg_addr = 6'h02; dbg_din = 16'h0004; dbg_wr = 1'b1; brk_halt = 2'b01;
    tick();
    dbg_wr = 1'b0; brk_halt = '0;
    chk("halt_stays_on_brk", 32'(dbg_halt_cmd), 32'd1);
    rd(6'h02, 16'h0024);
    wr(6'h02, 16'h0004);
    cpu_halt_st = 1'b1;
    rd(6'h02, 16'h0021);
    cpu_halt_st = 1'b0;
    brk_pnd = '0;

    // Single step
    wr(6'h01, 16'h0004);
    chk("step_cmd0", 32'(dbg_halt_cmd), 32'd0);
    tick();
    chk("step_wait", 32'(dbg_halt_cmd), 32'd0);
    wr(6'h01, 16'h0004);
    chk("step_istep_ignored", 32'(dbg_halt_cmd), 32'd0);
    rd(6'h01, 16'h0000);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("step_done_halt", 32'(dbg_halt_cmd), 32'd1);
    rd(6'h02, 16'h0002);
    wr(6'h02, 16'h0002);
    rd(6'h02, 16'h0000);

    // CPU reset release with RST_BRK_EN
    wr(6'h01, 16'h0002);
    chk("run_cmd", 32'(dbg_halt_cmd), 32'd0);
    wr(6'h01, 16'h0048);
    chk("cpu_reset_set", 32'(dbg_cpu_reset), 32'd1);
    chk("cpu_reset_running", 32'(dbg_halt_cmd), 32'd0);
    rd(6'h01, 16'h0048);
    wr(6'h01, 16'h0008);
    chk("cpu_reset_clr", 32'(dbg_cpu_reset), 32'd0);
    chk("rst_release_halt", 32'(dbg_halt_cmd), 32'd1);
    rd(6'h01, 16'h0008);

    // Command priority, then por during a step
    wr(6'h01, 16'h0003);
    chk("prio_halt_over_run", 32'(dbg_halt_cmd), 32'd1);
    wr(6'h01, 16'h0004);
    chk("step_again", 32'(dbg_halt_cmd), 32'd0);
    wr(6'h01, 16'h0040);
    chk("cpu_reset_in_step", 32'(dbg_cpu_reset), 32'd1);
    rd(6'h01, 16'h0040);
    tick();
    @(negedge mclk);
    por = 1'b1;
    #1;
    chk("por_halt_cmd", 32'(dbg_halt_cmd), 32'd0);
    chk("por_cpu_reset", 32'(dbg_cpu_reset), 32'd0);
    chk("por_dout", 32'(dbg_dout), 32'd0);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    por = 1'b0;
    tick();
    chk("after_por_run", 32'(dbg_halt_cmd), 32'd0);
    rd(6'h02, 16'h0000);

    // Simultaneous read and write returns the old value
    dbg_addr = 6'h01; dbg_din = 16'h0008; dbg_wr = 1'b1; dbg_rd = 1'b1;
    sb_q.push_back('{exp: 16'h0000, addr: 6'h01});
    tick();
    dbg_wr = 1'b0; dbg_rd = 1'b0;
    rd(6'h01, 16'h0008);
    rd(6'h1F, 16'h0000);

    tick(); tick();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_cpu_ctl.md
Name: dbg_cpu_ctl

Overview:
- Debug-side master for the hardware breakpoint units and the CPU run/halt controller.
- Decodes debug register accesses into per-unit register read/write selects and multiplexes their read data back.
- Consumes the breakpoint units' halt and pending outputs.
- Runs a RUN/HALT/STEP state machine that drives the frontend halt command.

Parameters:
- NB_BRK, 2, number of breakpoint units attached (1..4).
- CPU_ID, 16'h4D31, constant returned by the CPU_ID register.

Ports:
- mclk  input  1  main system clock.
- por  input  1  power-on reset, asynchronous, active-high.
- dbg_addr  input  6  debug register word address.
- dbg_din  input  16  debug write data; also routed to the breakpoint units.
- dbg_wr  input  1  debug register write strobe, one cycle per access.
- dbg_rd  input  1  debug register read strobe, one cycle per access.
- dbg_dout  output  16  registered read data.
- brk_reg_wr  output  4*NB_BRK  per-unit register write selects; unit k uses bits [4k+3:4k].
- brk_reg_rd  output  4*NB_BRK  per-unit register read selects.
- brk_dout  input  16*NB_BRK  per-unit read data; all zero when not selected.
- brk_halt  input  NB_BRK  per-unit breakpoint halt request.
- brk_pnd  input  NB_BRK  per-unit pending flag.
- exec_done  input  1  instruction execution completed.
- cpu_halt_st  input  1  CPU actually halted.
- dbg_halt_cmd  output  1  halt command to the frontend.
- dbg_cpu_reset  output  1  holds the CPU in reset.

Behaviour:

Reset:
- Reset is asynchronous and active-high on por; the single clock is mclk.
- On por: state=RUN, dbg_dout=0, dbg_halt_cmd=0, dbg_cpu_reset=0, all control and sticky bits cleared.
- por asserted mid-step or mid-halt forces RUN immediately, with no completion of the step.

Register map (word addresses):
- 0x00 CPU_ID: read-only.
- 0x01 CPU_CTL.
- 0x02 CPU_STAT.
- 0x08+4k+r: breakpoint unit k, register r (r: 0 CTL, 1 STAT, 2 ADDR0, 3 ADDR1), for k < NB_BRK.
- Any other address: reads return 0, writes are ignored.

Register access:
- brk_reg_wr[4k+r] = dbg_wr & (dbg_addr==8+4k+r), combinational. brk_reg_rd is decoded the same way from dbg_rd.
- Read latency is 1: the data selected at the strobe cycle N appears on dbg_dout at N+1 and holds until the next dbg_rd.
- Simultaneous dbg_rd and dbg_wr to the same address: the read returns the pre-write value.

CPU_CTL:
- bit0 HALT, bit1 RUN, bit2 ISTEP: write-1 commands, self-clearing, always read as 0.
- bit3 RST_BRK_EN: stored.
- bit6 CPU_RST: stored; drives dbg_cpu_reset directly.
- All other bits read 0.

CPU_STAT:
- bit0 HALT_ST = cpu_halt_st, live.
- bit1 STEP_DONE: sticky.
- bit2 BRK_EVT: sticky.
- bits[7:4] = brk_pnd, zero-extended; bits for absent units read 0.
- Writing 1 to bit1 or bit2 clears it. If a set event and the clear occur in the same cycle, the set wins.

State machine (Moore; dbg_halt_cmd = state!=RUN && !(state==STEP)):
- RUN -> HALT on any of:
  - a HALT write;
  - |brk_halt (also sets BRK_EVT);
  - a CPU_CTL write with CPU_RST 1->0 while RST_BRK_EN=1, whether already stored or written in the same write.
- HALT:
  - RUN write -> RUN.
  - ISTEP write -> STEP.
  - Command priority within one write: HALT > RUN > ISTEP.
- STEP:
  - dbg_halt_cmd=0.
  - On exec_done -> HALT and set STEP_DONE.
  - On |brk_halt or a HALT write -> HALT; STEP_DONE is set only if exec_done occurs in the same cycle.
  - RUN write -> RUN.
  - ISTEP write is ignored.
- Latency: an event at cycle N gives the new state and new dbg_halt_cmd at N+1.
- brk_halt while in HALT: stays in HALT; BRK_EVT is still set.

Test Plan:
- por, then read 0x00 -> dbg_dout=CPU_ID one cycle after dbg_rd. Read 0x05 -> 0.
- Write 0x0A (unit 0 ADDR0) with 16'h1234 -> only brk_reg_wr[2] high for exactly that cycle. With brk_dout[15:0]=16'h1234, read 0x0A -> dbg_dout=16'h1234 at N+1. Read 0x0C (unit 1 CTL) -> brk_reg_rd[4] asserted.
- In RUN, pulse brk_halt[1] at cycle N -> dbg_halt_cmd=1 at N+1 and CPU_STAT bit2=1. Write CPU_STAT 16'h0004 -> bit2 clears. Clear coincident with a new brk_halt -> bit2 stays 1.
- From HALT, write CPU_CTL 16'h0004 -> dbg_halt_cmd=0 until exec_done, =1 the cycle after exec_done, STEP_DONE=1. ISTEP written again during STEP -> no effect.
- Write CPU_CTL 16'h0048 -> dbg_cpu_reset=1. Then write 16'h0008 -> dbg_cpu_reset=0 and state HALT next cycle.
- Write CPU_CTL 16'h0003 while halted -> stays HALT (priority). Assert por during STEP -> state RUN, all outputs 0 immediately.
